nice_icb_osb: RTL and testbench

NICE_ICB_OSB -- requirements
Module: nice_icb_osb

---
 rtl/nice_icb_osb.sv | 154 +++++++++++++++
 tb/tb_nice_icb_osb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nice_icb_osb.sv
// NICE ICB outstanding buffer: credit-limits commands toward the LSU/BIU and
// buffers responses in a DEPTH-entry in-order FIFO toward the NICE core.
// Optional macro NICE_ICB_OSB_RSP_BYPASS_EN: zero-latency response bypass
// when the FIFO is empty and the upstream is ready.
module nice_icb_osb #(
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           nice_clk,
   input  logic                           nice_rst_n,
   // upstream command
   input  logic                           s_icb_cmd_valid,
   output logic                           s_icb_cmd_ready,
   input  logic [AW-1:0]                  s_icb_cmd_addr,
   input  logic                           s_icb_cmd_read,
   input  logic [DW-1:0]                  s_icb_cmd_wdata,
   input  logic [DW/8-1:0]                s_icb_cmd_wmask,
   input  logic [1:0]                     s_icb_cmd_size,
   // upstream response
   output logic                           s_icb_rsp_valid,
   input  logic                           s_icb_rsp_ready,
   output logic [DW-1:0]                  s_icb_rsp_rdata,
   output logic                           s_icb_rsp_err,
   // downstream command
   output logic                           m_icb_cmd_valid,
   input  logic                           m_icb_cmd_ready,
   output logic [AW-1:0]                  m_icb_cmd_addr,
   output logic                           m_icb_cmd_read,
   output logic [DW-1:0]                  m_icb_cmd_wdata,
   output logic [DW/8-1:0]                m_icb_cmd_wmask,
   output logic [1:0]                     m_icb_cmd_size,
   // downstream response
   input  logic                           m_icb_rsp_valid,
   output logic                           m_icb_rsp_ready,
   input  logic [DW-1:0]                  m_icb_rsp_rdata,
   input  logic                           m_icb_rsp_err,
   // status
   output logic                           osb_idle,
   output logic [$clog2(DEPTH+1)-1:0]     osb_cnt,
   output logic                           osb_proto_err
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned EW = DW + 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic          full_q, full_d;
   logic          perr_q, perr_d;
   logic [EW-1:0] mem_q [DEPTH];

   logic          credit_c, cmd_hs_c, rsp_hs_c, empty_c, expected_c;
   logic          bypass_c, push_c, pop_c;
   logic [CW-1:0] occ_c;
   logic [PW-1:0] wptr_inc_c, rptr_inc_c;

   // Command path: combinational forward gated by credit
   assign credit_c        = (cnt_q < CW'(DEPTH));
   assign m_icb_cmd_valid = s_icb_cmd_valid & credit_c;
   assign s_icb_cmd_ready = m_icb_cmd_ready & credit_c;
   assign m_icb_cmd_addr  = s_icb_cmd_addr;
   assign m_icb_cmd_read  = s_icb_cmd_read;
   assign m_icb_cmd_wdata = s_icb_cmd_wdata;
   assign m_icb_cmd_wmask = s_icb_cmd_wmask;
   assign m_icb_cmd_size  = s_icb_cmd_size;
   assign cmd_hs_c        = s_icb_cmd_valid & m_icb_cmd_ready & credit_c;

   // Credit guarantees FIFO space, so the downstream is never back-pressured
   assign m_icb_rsp_ready = 1'b1;

   // FIFO occupancy from pointers plus full flag
   always_comb begin
      occ_c = '0;
      if (full_q)
         occ_c = CW'(DEPTH);
      else if (wptr_q >= rptr_q)
         occ_c = CW'(wptr_q) - CW'(rptr_q);
      else
         occ_c = CW'(wptr_q) + CW'(DEPTH) - CW'(rptr_q);
   end

   assign empty_c    = (wptr_q == rptr_q) & ~full_q;
   assign expected_c = (cnt_q != occ_c);

`ifdef NICE_ICB_OSB_RSP_BYPASS_EN
   assign bypass_c = empty_c & m_icb_rsp_valid & expected_c & s_icb_rsp_ready;
`else
   assign bypass_c = 1'b0;
`endif

   assign push_c   = m_icb_rsp_valid & expected_c & ~bypass_c;
   assign pop_c    = s_icb_rsp_ready & ~empty_c;

   assign s_icb_rsp_valid = ~empty_c | bypass_c;
   assign {s_icb_rsp_rdata, s_icb_rsp_err} = bypass_c ? {m_icb_rsp_rdata, m_icb_rsp_err}
                                                      : mem_q[rptr_q];
   assign rsp_hs_c = s_icb_rsp_valid & s_icb_rsp_ready;

   assign wptr_inc_c = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
   assign rptr_inc_c = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;

   // Next-state for count, pointers, full flag and sticky protocol error
   always_comb begin
      cnt_d  = cnt_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      full_d = full_q;
      perr_d = perr_q;
      if (cmd_hs_c && !rsp_hs_c)
         cnt_d = cnt_q + 1'b1;
      else if (!cmd_hs_c && rsp_hs_c)
         cnt_d = cnt_q - 1'b1;
      if (push_c)
         wptr_d = wptr_inc_c;
      if (pop_c)
         rptr_d = rptr_inc_c;
      if (push_c && !pop_c)
         full_d = (wptr_inc_c == rptr_q);
      else if (pop_c && !push_c)
         full_d = 1'b0;
      if (m_icb_rsp_valid && !expected_c)
         perr_d = 1'b1;
   end

   // Control state registers
   always_ff @(posedge nice_clk or negedge nice_rst_n) begin
      if (!nice_rst_n) begin
         cnt_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         full_q <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         full_q <= full_d;
         perr_q <= perr_d;
      end
   end

   // Response storage; contents are don't-care until pushed
   always_ff @(posedge nice_clk) begin
      if (push_c)
         mem_q[wptr_q] <= {m_icb_rsp_rdata, m_icb_rsp_err};
   end

   assign osb_cnt       = cnt_q;
   assign osb_idle      = (cnt_q == '0);
   assign osb_proto_err = perr_q;

endmodule

// File: tb/tb_nice_icb_osb.sv
// Self-checking bench for nice_icb_osb (DEPTH=4, AW=DW=32).
module tb_nice_icb_osb;

   localparam int DEPTH = 4;

   logic        nice_clk, nice_rst_n;
   logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
   logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
   logic [3:0]  s_icb_cmd_wmask;
   logic [1:0]  s_icb_cmd_size;
   logic        s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
   logic [31:0] s_icb_rsp_rdata;
   logic        m_icb_cmd_valid, m_icb_cmd_ready, m_icb_cmd_read;
   logic [31:0] m_icb_cmd_addr, m_icb_cmd_wdata;
   logic [3:0]  m_icb_cmd_wmask;
   logic [1:0]  m_icb_cmd_size;
   logic        m_icb_rsp_valid, m_icb_rsp_ready, m_icb_rsp_err;
   logic [31:0] m_icb_rsp_rdata;
   logic        osb_idle, osb_proto_err;
   logic [2:0]  osb_cnt;

   int checks = 0;
   int failures = 0;

   // Reference model: outstanding count, queue of buffered {rdata, err}, sticky error
   int          cnt_m;
   logic [32:0] rsp_q[$];
   logic        perr_m;
   // Per-cycle predictions
   logic        p_credit, p_cmd_hs, p_unexp, p_byp, p_valid;
   logic [32:0] p_data;

   nice_icb_osb dut (
      .nice_clk(nice_clk), .nice_rst_n(nice_rst_n),
      .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
      .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
      .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
      .s_icb_cmd_size(s_icb_cmd_size),
      .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
      .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err),
      .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
      .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
      .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
      .m_icb_cmd_size(m_icb_cmd_size),
      .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
      .m_icb_rsp_rdata(m_icb_rsp_rdata), .m_icb_rsp_err(m_icb_rsp_err),
      .osb_idle(osb_idle), .osb_cnt(osb_cnt), .osb_proto_err(osb_proto_err)
   );

   initial nice_clk = 1'b0;
   always #5 nice_clk = ~nice_clk;

   // Apply one cycle of inputs at the falling edge and predict combinational outputs
   task automatic drive(input logic cv, input logic cr, input logic rv,
                        input logic [31:0] rd, input logic re, input logic sr);
      @(negedge nice_clk);
      s_icb_cmd_valid = cv;
      m_icb_cmd_ready = cr;
      m_icb_rsp_valid = rv;
      m_icb_rsp_rdata = rd;
      m_icb_rsp_err   = re;
      s_icb_rsp_ready = sr;
      s_icb_cmd_addr  = $urandom;
      s_icb_cmd_wdata = $urandom;
      s_icb_cmd_wmask = 4'($urandom);
      s_icb_cmd_read  = 1'($urandom);
      s_icb_cmd_size  = 2'($urandom);
      p_credit = (cnt_m < DEPTH);
      p_cmd_hs = cv & cr & p_credit;
      p_unexp  = rv && (cnt_m - rsp_q.size() == 0);
      p_byp    = 1'b0;
`ifdef NICE_ICB_OSB_RSP_BYPASS_EN
      p_byp    = rv && !p_unexp && (rsp_q.size() == 0) && sr;
`endif
      p_valid  = (rsp_q.size() > 0) || p_byp;
      p_data   = (rsp_q.size() > 0) ? rsp_q[0] : {rd, re};
      #1;
   endtask

   // Clock edge plus model update
   task automatic tick();
      logic rsp_hs;
      @(posedge nice_clk);
      rsp_hs = p_valid & s_icb_rsp_ready;
      if (rsp_hs && !p_byp) void'(rsp_q.pop_front());
      if (m_icb_rsp_valid) begin
         if (p_unexp) perr_m = 1'b1;
         else if (!p_byp) rsp_q.push_back({m_icb_rsp_rdata, m_icb_rsp_err});
      end
      cnt_m = cnt_m + (p_cmd_hs ? 1 : 0) - (rsp_hs ? 1 : 0);
      #1;
   endtask

   task automatic model_clear();
      cnt_m = 0;
      rsp_q.delete();
      perr_m = 1'b0;
   endtask

   // Return every outstanding response with upstream ready until idle
   task automatic drain();
      int n = 0;
      while ((cnt_m != 0 || rsp_q.size() != 0) && n < 100) begin
         drive(1'b0, 1'b1, (cnt_m - rsp_q.size()) > 0, $urandom, 1'b0, 1'b1);
         tick();
         n++;
      end
      checks++;
      if (osb_idle !== 1'b1 || n >= 100) begin
         failures++;
         $display("FAIL drain: osb_idle=%b cycles=%0d required idle=1 within 100", osb_idle, n);
      end
   endtask

   task automatic test_reset();
      nice_rst_n = 1'b0;
      model_clear();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (s_icb_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b need 0", s_icb_rsp_valid); end
      checks++;
      if (osb_idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b need 1", osb_idle); end
      checks++;
      if (osb_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt: got %0d need 0", osb_cnt); end
      checks++;
      if (m_icb_rsp_ready !== 1'b1) begin failures++; $display("FAIL reset_m_rsp_ready: got %b need 1", m_icb_rsp_ready); end
      checks++;
      if (s_icb_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b need 1", s_icb_cmd_ready); end
      checks++;
      if (osb_proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto: got %b need 0", osb_proto_err); end
      @(negedge nice_clk);
      nice_rst_n = 1'b1;
   endtask

   task automatic test_credit();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         checks++;
         if (s_icb_cmd_ready !== (i < DEPTH) || m_icb_cmd_valid !== (i < DEPTH)) begin
            failures++;
            $display("FAIL credit_ready[%0d]: ready=%b valid=%b need %b", i, s_icb_cmd_ready, m_icb_cmd_valid, i < DEPTH);
         end
         tick();
      end
      checks++;
      if (osb_cnt !== 3'd4) begin failures++; $display("FAIL credit_cnt: got %0d need 4", osb_cnt); end
   endtask

   task automatic test_order();
      logic [31:0] want;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b1, 32'hA1 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      checks++;
      if (s_icb_rsp_valid !== 1'b1 || osb_cnt !== 3'd4) begin
         failures++; $display("FAIL order_buffered: valid=%b cnt=%0d need 1/4", s_icb_rsp_valid, osb_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
         want = 32'hA1 + 32'(i);
         checks++;
         if (s_icb_rsp_valid !== 1'b1 || s_icb_rsp_rdata !== want) begin
            failures++;
            $display("FAIL order_data[%0d]: valid=%b rdata=%h need 1/%h", i, s_icb_rsp_valid, s_icb_rsp_rdata, want);
         end
         tick();
      end
      checks++;
      if (osb_idle !== 1'b1 || s_icb_rsp_valid !== 1'b0) begin
         failures++; $display("FAIL order_idle: idle=%b valid=%b need 1/0", osb_idle, s_icb_rsp_valid);
      end
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick(); end
      for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, 1'b1, $urandom, 1'b0, 1'b0); tick(); end
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (s_icb_cmd_ready !== 1'b0 || s_icb_rsp_valid !== 1'b1 || s_icb_rsp_rdata !== p_data[32:1]) begin
         failures++;
         $display("FAIL fullpop_same: ready=%b valid=%b rdata=%h need 0/1/%h", s_icb_cmd_ready, s_icb_rsp_valid, s_icb_rsp_rdata, p_data[32:1]);
      end
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (s_icb_cmd_ready !== 1'b1) begin failures++; $display("FAIL fullpop_next_ready: got %b need 1", s_icb_cmd_ready); end
      tick();
      checks++;
      if (osb_cnt !== 3'd4) begin failures++; $display("FAIL fullpop_cnt: got %0d need 4", osb_cnt); end
      drain();
   endtask

   task automatic test_latency();
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b1);
`ifdef NICE_ICB_OSB_RSP_BYPASS_EN
      checks++;
      if (s_icb_rsp_valid !== 1'b1 || s_icb_rsp_rdata !== 32'h5A5A5A5A) begin
         failures++; $display("FAIL latency_bypass: valid=%b rdata=%h need 1/5a5a5a5a", s_icb_rsp_valid, s_icb_rsp_rdata);
      end
`else
      checks++;
      if (s_icb_rsp_valid !== 1'b0) begin failures++; $display("FAIL latency_same_cycle: valid=%b need 0", s_icb_rsp_valid); end
`endif
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
`ifdef NICE_ICB_OSB_RSP_BYPASS_EN
      checks++;
      if (s_icb_rsp_valid !== 1'b0) begin failures++; $display("FAIL latency_after_bypass: valid=%b need 0", s_icb_rsp_valid); end
`else
      checks++;
      if (s_icb_rsp_valid !== 1'b1 || s_icb_rsp_rdata !== 32'h5A5A5A5A) begin
         failures++; $display("FAIL latency_next_cycle: valid=%b rdata=%h need 1/5a5a5a5a", s_icb_rsp_valid, s_icb_rsp_rdata);
      end
`endif
      tick();
      checks++;
      if (osb_idle !== 1'b1) begin failures++; $display("FAIL latency_idle: got %b need 1", osb_idle); end
   endtask

   task automatic test_random();
      logic cv, cr, rv, sr;
      for (int i = 0; i < 400; i++) begin
         cv = 1'($urandom);
         cr = ($urandom_range(0, 3) != 0);
         rv = ((cnt_m - rsp_q.size()) > 0) && ($urandom_range(0, 1) == 1);
         sr = ($urandom_range(0, 2) != 0);
         drive(cv, cr, rv, $urandom, 1'($urandom), sr);
         checks++;
         if (s_icb_cmd_ready !== (cr & p_credit) || m_icb_cmd_valid !== (cv & p_credit)) begin
            failures++;
            $display("FAIL rand_cmd[%0d]: ready=%b valid=%b need %b/%b", i, s_icb_cmd_ready, m_icb_cmd_valid, cr & p_credit, cv & p_credit);
         end
         checks++;
         if (m_icb_cmd_addr !== s_icb_cmd_addr || m_icb_cmd_wdata !== s_icb_cmd_wdata ||
             m_icb_cmd_wmask !== s_icb_cmd_wmask || m_icb_cmd_read !== s_icb_cmd_read ||
             m_icb_cmd_size !== s_icb_cmd_size) begin
            failures++;
            $display("FAIL rand_pass[%0d]: addr=%h need %h wdata=%h need %h", i, m_icb_cmd_addr, s_icb_cmd_addr, m_icb_cmd_wdata, s_icb_cmd_wdata);
         end
         checks++;
         if (s_icb_rsp_valid !== p_valid || (p_valid && {s_icb_rsp_rdata, s_icb_rsp_err} !== p_data)) begin
            failures++;
            $display("FAIL rand_rsp[%0d]: valid=%b data=%h need %b/%h", i, s_icb_rsp_valid, {s_icb_rsp_rdata, s_icb_rsp_err}, p_valid, p_data);
         end
         tick();
         checks++;
         if (osb_cnt !== 3'(cnt_m) || osb_idle !== (cnt_m == 0) || osb_proto_err !== perr_m) begin
            failures++;
            $display("FAIL rand_state[%0d]: cnt=%0d idle=%b perr=%b need %0d/%b/%b", i, osb_cnt, osb_idle, osb_proto_err, cnt_m, cnt_m == 0, perr_m);
         end
      end
      drain();
   endtask

   task automatic test_proto();
      drive(1'b0, 1'b1, 1'b1, 32'hDEAD0001, 1'b0, 1'b1);
      checks++;
      if (s_icb_rsp_valid !== 1'b0) begin failures++; $display("FAIL proto_no_valid: got %b need 0", s_icb_rsp_valid); end
      tick();
      checks++;
      if (osb_proto_err !== 1'b1 || osb_cnt !== 3'd0 || s_icb_rsp_valid !== 1'b0) begin
         failures++; $display("FAIL proto_set: perr=%b cnt=%0d valid=%b need 1/0/0", osb_proto_err, osb_cnt, s_icb_rsp_valid);
      end
      for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1); tick(); end
      checks++;
      if (osb_proto_err !== 1'b1 || s_icb_rsp_valid !== 1'b0) begin
         failures++; $display("FAIL proto_sticky: perr=%b valid=%b need 1/0", osb_proto_err, s_icb_rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick(); end
      for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b1, 1'b1, $urandom, 1'b0, 1'b0); tick(); end
      checks++;
      if (osb_cnt !== 3'd3 || s_icb_rsp_valid !== 1'b1) begin
         failures++; $display("FAIL rstmid_pre: cnt=%0d valid=%b need 3/1", osb_cnt, s_icb_rsp_valid);
      end
      @(negedge nice_clk);
      #2 nice_rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (osb_cnt !== 3'd0 || s_icb_rsp_valid !== 1'b0 || osb_idle !== 1'b1 || osb_proto_err !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_async: cnt=%0d valid=%b idle=%b perr=%b need 0/0/1/0", osb_cnt, s_icb_rsp_valid, osb_idle, osb_proto_err);
      end
      @(negedge nice_clk);
      nice_rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1);
      tick();
      checks++;
      if (osb_proto_err !== 1'b1 || s_icb_rsp_valid !== 1'b0 || osb_cnt !== 3'd0) begin
         failures++; $display("FAIL rstmid_late_rsp: perr=%b valid=%b cnt=%0d need 1/0/0", osb_proto_err, s_icb_rsp_valid, osb_cnt);
      end
   endtask

   initial begin
      s_icb_cmd_valid = 1'b0; m_icb_cmd_ready = 1'b0; m_icb_rsp_valid = 1'b0;
      m_icb_rsp_rdata = '0; m_icb_rsp_err = 1'b0; s_icb_rsp_ready = 1'b0;
      s_icb_cmd_addr = '0; s_icb_cmd_wdata = '0; s_icb_cmd_wmask = '0;
      s_icb_cmd_read = 1'b0; s_icb_cmd_size = '0;
      test_reset();
      test_credit();
      test_order();
      test_full_pop();
      test_latency();
      test_random();
      test_proto();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
